// File: rtl/control_inputs_conditioner.sv
// Conditions the board keys and slide switches for the audio system PIO inputs:
// 2-FF synchronisers, per-input debouncers, next/previous hold pulses,
// a toggled pause level and a prioritised pair of filter enables.
//
// state    | meaning
// ---------+---------------------------------------------
// IDLE     | no next/previous pulse in progress
// HOLD_ANT | previous-track pulse high, hold counter running
// HOLD_SIG | next-track pulse high, hold counter running
module control_inputs_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 5_000_000,
  parameter int CNT_W           = 23
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic key_anterior_n,
  input  logic key_siguiente_n,
  input  logic key_pausa_n,
  input  logic sw_filt1,
  input  logic sw_filt2,
  input  logic pause_clr,
  output logic anterior_sw_export,
  output logic siguiente_sw_export,
  output logic pausa_sw_export,
  output logic filt1_sw_export,
  output logic filt2_sw_export
);

  // Bit order: 0 anterior, 1 siguiente, 2 pausa, 3 filt1, 4 filt2.
  // Keys idle high (released), switches idle low.
  localparam logic [4:0]       IDLE_LEVELS = 5'b00111;
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD_ANT, HOLD_SIG} state_t;

  logic [4:0]       raw;
  logic [4:0]       sync1;
  logic [4:0]       sync2;
  logic [4:0]       db;
  logic [CNT_W-1:0] db_cnt [5];
  logic [2:0]       db_d;
  logic [2:0]       press;
  logic             ev_ant;
  logic             ev_sig;
  logic             ev_pau;
  state_t           state;
  logic [CNT_W-1:0] hold_cnt;

  assign raw    = {sw_filt2, sw_filt1, key_pausa_n, key_siguiente_n, key_anterior_n};
  assign press  = db_d & ~db[2:0];
  assign ev_ant = press[0];
  assign ev_sig = press[1];
  assign ev_pau = press[2];

  // Two-stage synchroniser for the asynchronous board inputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1 <= IDLE_LEVELS;
      sync2 <= IDLE_LEVELS;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debouncers: accept a new level once it has differed for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      db <= IDLE_LEVELS;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Previous debounced key levels, used to find the 1->0 press edge.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) db_d <= IDLE_LEVELS[2:0];
    else                db_d <= db[2:0];
  end

  // Next/previous pulse FSM; simultaneous presses on both keys are discarded.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state               <= IDLE;
      hold_cnt            <= '0;
      anterior_sw_export  <= 1'b0;
      siguiente_sw_export <= 1'b0;
    end else if (ev_ant && !ev_sig) begin
      state               <= HOLD_ANT;
      hold_cnt            <= '0;
      anterior_sw_export  <= 1'b1;
      siguiente_sw_export <= 1'b0;
    end else if (ev_sig && !ev_ant) begin
      state               <= HOLD_SIG;
      hold_cnt            <= '0;
      anterior_sw_export  <= 1'b0;
      siguiente_sw_export <= 1'b1;
    end else if (state != IDLE) begin
      if (hold_cnt == HOLD_LAST) begin
        state               <= IDLE;
        hold_cnt            <= '0;
        anterior_sw_export  <= 1'b0;
        siguiente_sw_export <= 1'b0;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // Pause toggles on each press; a clear request overrides a coincident press.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  pausa_sw_export <= 1'b0;
    else if (pause_clr)  pausa_sw_export <= 1'b0;
    else if (ev_pau)     pausa_sw_export <= ~pausa_sw_export;
  end

  // Filter enables; filter 1 masks filter 2.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      filt1_sw_export <= 1'b0;
      filt2_sw_export <= 1'b0;
    end else begin
      filt1_sw_export <= db[3];
      filt2_sw_export <= db[4] & ~db[3];
    end
  end

endmodule
